fetch_translate_queue: RTL and testbench

FETCH_TRANSLATE_QUEUE -- requirements
Module: fetch_translate_queue

---
 rtl/fetch_translate_queue_pkg.sv | 26 ++
 rtl/fetch_translate_queue.sv | 128 ++++++++++++
 tb/tb_fetch_translate_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_translate_queue_pkg.sv
// Shared RV fetch types.
//
// Holds the virtual/physical address types used by the front end and the
// entry record carried through the fetch translate queue. Anything that
// produces or consumes translated fetch addresses imports this package.
package fetch_translate_queue_pkg;

    typedef logic [31:0] vaddr_t;
    typedef logic [33:0] paddr_t;

    // One translated fetch: the PC in both address spaces plus the two TLB
    // outcome flags. Both flags may be set together; they travel unchanged.
    typedef struct packed {
        vaddr_t vaddr;
        paddr_t paddr;
        logic   tlbFault;
        logic   tlbMiss;
    } FetchTranslateEntry;

    // An entry carrying either TLB outcome must stop further fetches from
    // being queued behind it until it has been consumed.
    function automatic logic isBlocking(input FetchTranslateEntry entry);
        return entry.tlbFault | entry.tlbMiss;
    endfunction

endpackage

// File: rtl/fetch_translate_queue.sv
// Fetch translate queue.
//
// Small FIFO between address translation and the instruction fetch stage.
// Each entry holds a fetch PC (virtual and physical) together with the TLB
// fault/miss flags. Once an entry with either flag set has been queued, the
// queue stops accepting new fetches until that entry has been popped, so the
// faulting/missing fetch is always the youngest entry. A flush (redirect or
// trap) throws every entry away in one cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           discard all entries; overrides push and pop this cycle
//   inValid/inReady producer handshake, push on inValid && inReady
//   inVaddr/inPaddr translated fetch PC
//   inTlbFault/Miss translation outcome flags
//   outValid/outReady consumer handshake, pop on outValid && outReady
//   out*            head entry fields, meaningful only while outValid=1
//   count           number of occupied entries (0..DEPTH)
//   blocked         a fault/miss entry is queued and pushes are stalled
module fetch_translate_queue
    import fetch_translate_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [31:0]              inVaddr,
    input  logic [33:0]              inPaddr,
    input  logic                     inTlbFault,
    input  logic                     inTlbMiss,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              outVaddr,
    output logic [33:0]              outPaddr,
    output logic                     outTlbFault,
    output logic                     outTlbMiss,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     blocked
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // The pointer arithmetic relies on natural wrap of a PW-bit counter, so
    // only power-of-two depths of at least two entries are meaningful.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("fetch_translate_queue: DEPTH must be a power of two >= 2");
    end

    FetchTranslateEntry storage [DEPTH];

    logic [PW-1:0]      rdPtr;
    logic [PW-1:0]      wrPtr;
    logic [CW-1:0]      countQ;
    logic               blockedQ;
    logic               full;
    logic               doPush;
    logic               doPop;
    FetchTranslateEntry inEntry;
    FetchTranslateEntry headEntry;

    assign inEntry = '{vaddr: inVaddr, paddr: inPaddr,
                       tlbFault: inTlbFault, tlbMiss: inTlbMiss};

    // Handshakes depend only on registered state and flush, never on the
    // opposite side's valid/ready, so no combinational path crosses the queue.
    assign full     = (countQ == CW'(DEPTH));
    assign inReady  = !full && !blockedQ && !flush;
    assign outValid = (countQ != '0) && !flush;
    assign doPush   = inValid && inReady;
    assign doPop    = outValid && outReady;

    // Pointer, occupancy and blocked tracking. Flush takes priority over any
    // handshake this cycle because both handshakes are already masked by it.
    // The blocking entry is always the tail, so when a pop empties the queue
    // while blocked it is that entry leaving and the stall can lift. A
    // blocking push in the same cycle as a pop must win, hence its priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            countQ   <= '0;
            blockedQ <= 1'b0;
        end else if (flush) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            countQ   <= '0;
            blockedQ <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
            if (doPush && isBlocking(inEntry)) begin
                blockedQ <= 1'b1;
            end else if (doPop && countQ == CW'(1)) begin
                blockedQ <= 1'b0;
            end
        end
    end

    // Entry storage is deliberately left out of reset; the head fields are
    // only qualified by outValid, which reset already clears.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= inEntry;
        end
    end

    assign headEntry   = storage[rdPtr];
    assign outVaddr    = headEntry.vaddr;
    assign outPaddr    = headEntry.paddr;
    assign outTlbFault = headEntry.tlbFault;
    assign outTlbMiss  = headEntry.tlbMiss;
    assign count       = countQ;
    assign blocked     = blockedQ;

endmodule

// File: tb/tb_fetch_translate_queue.sv
// Testbench for fetch_translate_queue.
//
// Directed vectors drive the producer/consumer sides; every accepted push
// records the entry it carried in a scoreboard queue, and a monitor branch
// pops and compares whenever the DUT hands out its head entry. Occupancy,
// handshake and blocked values are checked against hand-computed constants.
module tb_fetch_translate_queue;
    import fetch_translate_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] inVaddr;
    logic [33:0] inPaddr;
    logic        inTlbFault;
    logic        inTlbMiss;
    logic        outValid;
    logic        outReady;
    logic [31:0] outVaddr;
    logic [33:0] outPaddr;
    logic        outTlbFault;
    logic        outTlbMiss;
    logic [$clog2(DEPTH):0] count;
    logic        blocked;

    FetchTranslateEntry expQ[$];
    int errors;
    int checks;

    fetch_translate_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .inVaddr    (inVaddr),
        .inPaddr    (inPaddr),
        .inTlbFault (inTlbFault),
        .inTlbMiss  (inTlbMiss),
        .outValid   (outValid),
        .outReady   (outReady),
        .outVaddr   (outVaddr),
        .outPaddr   (outPaddr),
        .outTlbFault(outTlbFault),
        .outTlbMiss (outTlbMiss),
        .count      (count),
        .blocked    (blocked)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set all inputs for the coming cycle; paddr is derived from vaddr so each
    // entry carries a distinct, predictable physical address.
    task automatic drive(input logic v, input logic [31:0] va, input logic fault,
                         input logic miss, input logic ordy, input logic fl);
        inValid    = v;
        inVaddr    = va;
        inPaddr    = {2'b10, va ^ 32'h0000_F000};
        inTlbFault = fault;
        inTlbMiss  = miss;
        outReady   = ordy;
        flush      = fl;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] va, input logic fault,
                                 input logic miss, input logic ordy, input logic fl);
        drive(v, va, fault, miss, ordy, fl);
        step();
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle();

        // Scoreboard monitor: runs alongside the stimulus, sampling mid-cycle.
        fork
            begin : monitor
                FetchTranslateEntry expEntry;
                FetchTranslateEntry gotEntry;
                forever begin
                    @(negedge clk);
                    if (rst || flush) begin
                        expQ.delete();
                    end else begin
                        if (outValid && outReady) begin
                            checks++;
                            gotEntry = '{vaddr: outVaddr, paddr: outPaddr,
                                         tlbFault: outTlbFault, tlbMiss: outTlbMiss};
                            if (expQ.size() == 0) begin
                                errors++;
                                $display("[TB] FAIL pop: got %0h with nothing expected", gotEntry);
                            end else begin
                                expEntry = expQ.pop_front();
                                if (gotEntry !== expEntry) begin
                                    errors++;
                                    $display("[TB] FAIL pop data: got %0h, expected %0h",
                                             gotEntry, expEntry);
                                end
                            end
                        end
                        if (inValid && inReady) begin
                            expQ.push_back('{vaddr: inVaddr, paddr: inPaddr,
                                             tlbFault: inTlbFault, tlbMiss: inTlbMiss});
                        end
                    end
                end
            end
        join_none

        step();
        step();
        rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset count", 32'(count), 0);
        checkOutput("reset outValid", 32'(outValid), 0);
        checkOutput("reset inReady", 32'(inReady), 1);
        checkOutput("reset blocked", 32'(blocked), 0);

        $display("[TB] fill and drain");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        #1;
        checkOutput("fill count", 32'(count), 4);
        checkOutput("fill inReady", 32'(inReady), 0);
        checkOutput("fill outValid", 32'(outValid), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain count", 32'(count), 0);
        checkOutput("drain outValid", 32'(outValid), 0);

        $display("[TB] pointer wrap");
        applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h3008 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("wrap count", 32'(count), 2);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap drained", 32'(count), 0);

        $display("[TB] blocking entry");
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2004, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("block set", 32'(blocked), 1);
        checkOutput("block inReady", 32'(inReady), 0);
        checkOutput("block count", 32'(count), 2);
        applyStimulus(1'b1, 32'h2008, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("block push rejected", 32'(count), 2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("block first pop count", 32'(count), 1);
        checkOutput("block held", 32'(blocked), 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("block second pop count", 32'(count), 0);
        checkOutput("block cleared", 32'(blocked), 0);

        $display("[TB] blocking push with same-cycle pop");
        applyStimulus(1'b1, 32'h2100, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2104, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("pushpop count", 32'(count), 1);
        checkOutput("pushpop blocked", 32'(blocked), 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pushpop cleared", 32'(blocked), 0);
        checkOutput("pushpop empty", 32'(count), 0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5004, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5008, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("preflush count", 32'(count), 3);
        checkOutput("preflush blocked", 32'(blocked), 1);
        drive(1'b1, 32'h500C, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("flush inReady", 32'(inReady), 0);
        checkOutput("flush outValid", 32'(outValid), 0);
        step();
        idle();
        #1;
        checkOutput("postflush count", 32'(count), 0);
        checkOutput("postflush blocked", 32'(blocked), 0);
        checkOutput("postflush outValid", 32'(outValid), 0);
        checkOutput("postflush inReady", 32'(inReady), 1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4004, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("prereset count", 32'(count), 2);
        checkOutput("prereset blocked", 32'(blocked), 1);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midreset count", 32'(count), 0);
        checkOutput("midreset blocked", 32'(blocked), 0);
        checkOutput("midreset inReady", 32'(inReady), 1);
        checkOutput("midreset outValid", 32'(outValid), 0);
        applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after reset push", 32'(count), 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("after reset pop", 32'(count), 0);

        idle();
        step();
        checkOutput("scoreboard empty", 32'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
